// File: rtl/lock_update_release_if.sv
// Bundle of the three handshakes lock_update_release sits between:
// the lock_read_fifo pop port, the Avalon-MM memory port and the
// lock arbiter release port. The master modport is the updater side.
interface lock_update_release_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_WIDTH = 65
);
    // lock_read_fifo pop port
    logic [FIFO_WIDTH-1:0] lock_read_fifo_q;
    logic                  lock_read_fifo_empty;
    logic                  lock_read_fifo_rdreq;

    // Avalon-MM memory port
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_writedata;
    logic [DATA_WIDTH-1:0] mem_readdata;
    logic                  mem_readdatavalid;
    logic                  mem_waitrequest;

    // lock arbiter release port
    logic [DATA_WIDTH-1:0] proc_release_key;
    logic                  proc_release_req;
    logic                  proc_release_ack;

    modport master (
        input  lock_read_fifo_q,
        input  lock_read_fifo_empty,
        output lock_read_fifo_rdreq,
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_writedata,
        input  mem_readdata,
        input  mem_readdatavalid,
        input  mem_waitrequest,
        output proc_release_key,
        output proc_release_req,
        input  proc_release_ack
    );

    modport slave (
        output lock_read_fifo_q,
        output lock_read_fifo_empty,
        input  lock_read_fifo_rdreq,
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_writedata,
        output mem_readdata,
        output mem_readdatavalid,
        output mem_waitrequest,
        input  proc_release_key,
        input  proc_release_req,
        output proc_release_ack
    );
endinterface

// File: rtl/lock_update_release.sv
// lock_update_release: pops one lock-held entry from lock_read_fifo,
// read-modify-writes (accumulate) or writes (overwrite) the key's value
// word in memory, then hands the key lock back to the arbiter.
// One entry is in flight at a time; every output is a register.
module lock_update_release #(
    parameter int                    DATA_WIDTH           = 32,
    parameter int                    LOCK_READ_FIFO_WIDTH = 65,
    parameter int                    ADDR_WIDTH           = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR            = '0,
    parameter int                    RD_TIMEOUT           = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    lock_update_release_if.master    bus,
    output logic [31:0]              updates_done,
    output logic                     rd_timeout_err
);

    // Entry layout: {op, key, value}; op=1 accumulates, op=0 overwrites.
    localparam int OP_BIT = 2 * DATA_WIDTH;
    localparam int TW     = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RD_TIMEOUT);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ_FIFO = 3'd1;
    localparam logic [2:0] LATCH     = 3'd2;
    localparam logic [2:0] MEM_RD    = 3'd3;
    localparam logic [2:0] WAIT_RD   = 3'd4;
    localparam logic [2:0] MEM_WR    = 3'd5;
    localparam logic [2:0] RELEASE   = 3'd6;

    // Word address of a key's value: byte base plus key*4, wrapped to the bus width.
    function automatic logic [ADDR_WIDTH-1:0] key_addr(input logic [DATA_WIDTH-1:0] key);
        return BASE_ADDR + ADDR_WIDTH'({key, 2'b00});
    endfunction

    // Accumulate is modular: the carry out of the word is dropped.
    function automatic logic [DATA_WIDTH-1:0] add_wrap(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return a + b;
    endfunction

    logic [2:0]             state, state_nxt;
    logic                   entry_op, entry_op_nxt;
    logic [DATA_WIDTH-1:0]  entry_key, entry_key_nxt;
    logic [DATA_WIDTH-1:0]  entry_val, entry_val_nxt;
    logic [TW-1:0]          timer, timer_nxt;

    logic                   pop, pop_nxt;
    logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
    logic                   rd, rd_nxt;
    logic                   wr, wr_nxt;
    logic [DATA_WIDTH-1:0]  wdata, wdata_nxt;
    logic                   rel_req, rel_req_nxt;
    logic [DATA_WIDTH-1:0]  rel_key, rel_key_nxt;
    logic [31:0]            done_cnt, done_cnt_nxt;
    logic                   timeout_flag, timeout_flag_nxt;

    logic                   q_op;
    logic [DATA_WIDTH-1:0]  q_key;
    logic [DATA_WIDTH-1:0]  q_val;

    assign q_op  = bus.lock_read_fifo_q[OP_BIT];
    assign q_key = bus.lock_read_fifo_q[OP_BIT-1:DATA_WIDTH];
    assign q_val = bus.lock_read_fifo_q[DATA_WIDTH-1:0];

    assign bus.lock_read_fifo_rdreq = pop;
    assign bus.mem_address          = addr;
    assign bus.mem_read             = rd;
    assign bus.mem_write            = wr;
    assign bus.mem_writedata        = wdata;
    assign bus.proc_release_req     = rel_req;
    assign bus.proc_release_key     = rel_key;
    assign updates_done             = done_cnt;
    assign rd_timeout_err           = timeout_flag;

    // Next-state and next-output decode; every register holds unless its state acts on it.
    always_comb begin
        state_nxt        = state;
        entry_op_nxt     = entry_op;
        entry_key_nxt    = entry_key;
        entry_val_nxt    = entry_val;
        timer_nxt        = timer;
        pop_nxt          = 1'b0;
        addr_nxt         = addr;
        rd_nxt           = rd;
        wr_nxt           = wr;
        wdata_nxt        = wdata;
        rel_req_nxt      = rel_req;
        rel_key_nxt      = rel_key;
        done_cnt_nxt     = done_cnt;
        timeout_flag_nxt = timeout_flag;

        case (state)
            IDLE: begin
                // empty is only looked at here, so entries queue up while busy.
                if (!bus.lock_read_fifo_empty) begin
                    pop_nxt   = 1'b1;
                    state_nxt = READ_FIFO;
                end
            end

            READ_FIFO: begin
                // The FIFO presents q the cycle after the pop pulse.
                state_nxt = LATCH;
            end

            LATCH: begin
                entry_op_nxt  = q_op;
                entry_key_nxt = q_key;
                entry_val_nxt = q_val;
                addr_nxt      = key_addr(q_key);
                if (q_op) begin
                    rd_nxt    = 1'b1;
                    state_nxt = MEM_RD;
                end else begin
                    wr_nxt    = 1'b1;
                    wdata_nxt = q_val;
                    state_nxt = MEM_WR;
                end
            end

            MEM_RD: begin
                if (!bus.mem_waitrequest) begin
                    rd_nxt    = 1'b0;
                    timer_nxt = TIMER_LOAD;
                    state_nxt = WAIT_RD;
                end
            end

            WAIT_RD: begin
                // Data arriving on the expiry cycle still wins over the timeout.
                if (bus.mem_readdatavalid) begin
                    wdata_nxt = add_wrap(bus.mem_readdata, entry_val);
                    wr_nxt    = 1'b1;
                    state_nxt = MEM_WR;
                end else if (timer == '0) begin
                    timeout_flag_nxt = 1'b1;
                    rel_req_nxt      = 1'b1;
                    rel_key_nxt      = entry_key;
                    state_nxt        = RELEASE;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end

            MEM_WR: begin
                if (!bus.mem_waitrequest) begin
                    wr_nxt       = 1'b0;
                    done_cnt_nxt = done_cnt + 32'd1;
                    rel_req_nxt  = 1'b1;
                    rel_key_nxt  = entry_key;
                    state_nxt    = RELEASE;
                end
            end

            RELEASE: begin
                // An ack in the very first request cycle is accepted.
                if (bus.proc_release_ack) begin
                    rel_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched entry, timer and all registered outputs; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            entry_op     <= 1'b0;
            entry_key    <= '0;
            entry_val    <= '0;
            timer        <= '0;
            pop          <= 1'b0;
            addr         <= '0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            wdata        <= '0;
            rel_req      <= 1'b0;
            rel_key      <= '0;
            done_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            entry_op     <= entry_op_nxt;
            entry_key    <= entry_key_nxt;
            entry_val    <= entry_val_nxt;
            timer        <= timer_nxt;
            pop          <= pop_nxt;
            addr         <= addr_nxt;
            rd           <= rd_nxt;
            wr           <= wr_nxt;
            wdata        <= wdata_nxt;
            rel_req      <= rel_req_nxt;
            rel_key      <= rel_key_nxt;
            done_cnt     <= done_cnt_nxt;
            timeout_flag <= timeout_flag_nxt;
        end
    end

endmodule
